mat_mult_arb: RTL and testbench
===============================

MAT_MULT_ARB -- requirements
Module: mat_mult_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one multiplier.
REQ-002 Parameter A_ROWS, default 4: rows of A and of C.
REQ-003 Parameter A_COLS, default 8: columns of A, which equals rows of B.
REQ-004 Parameter B_COLS, default 1: columns of B and of C.
REQ-005 clk  in  1: clock; all state updates on posedge clk.
REQ-006 rst  in  1: reset, synchronous, active-high.
REQ-007 req_valid  in  NUM_REQ: per-requester job request.
REQ-008 req_ready  out  NUM_REQ: per-requester accept; at most one bit high per cycle.
REQ-009 req_a  in  NUM_REQ x A_ROWS x A_COLS: per-requester A matrix over GF(2).
REQ-010 req_b  in  NUM_REQ x A_COLS x B_COLS: per-requester B matrix over GF(2).
REQ-011 mul_a  out  A_ROWS x A_COLS: registered A operand driven to the shared multiplier.
REQ-012 mul_b  out  A_COLS x B_COLS: registered B operand driven to the shared multiplier.
REQ-013 mul_c  in  A_ROWS x B_COLS: multiplier result; the multiplier has 1-cycle registered latency and no enable.
REQ-014 resp_valid  out  1: result available.
REQ-015 resp_ready  in  1: downstream accepts the result.
REQ-016 resp_c  out  A_ROWS x B_COLS: result matrix.
REQ-017 resp_id  out  clog2(NUM_REQ): index of the requester that owns resp_c.
REQ-018 busy  out  1: high in every state except IDLE.

Function
REQ-019 The FSM SHALL have 3 states: IDLE, LOAD, RESP.
REQ-020 In IDLE, the combinational grant SHALL select the first asserted req_valid bit at or after rr_ptr, searching upward with wrap-around.
REQ-021 req_ready[i] SHALL be 1 only when state=IDLE and grant[i]=1, and 0 in all other states; this combinational valid-to-ready path is permitted.
REQ-022 On accept (IDLE, any req_valid), the block SHALL register mul_a/mul_b from the granted req_a/req_b, register resp_id to the grant index, set rr_ptr to (grant+1) mod NUM_REQ, and go to LOAD.
REQ-023 In IDLE with no req_valid, all state SHALL hold.
REQ-024 LOAD SHALL last exactly 1 cycle, then go to RESP.
REQ-025 In RESP: resp_valid=1, resp_c=mul_c; mul_a/mul_b SHALL stay stable so mul_c stays constant.
REQ-026 In RESP with resp_ready=1, the block SHALL go to IDLE; otherwise it SHALL stay in RESP with resp_c and resp_id unchanged.
REQ-027 Latency SHALL be: accept at cycle T gives resp_valid at T+2; minimum issue interval 3 cycles.
REQ-028 req_valid changes outside IDLE SHALL have no effect; a requester holds its data until its req_ready.
REQ-029 GF(2) arithmetic is performed only in the multiplier; this block does no arithmetic beyond rr_ptr wrap.
REQ-030 NUM_REQ=1 SHALL be legal: resp_id width 1, always 0.

Reset
REQ-031 When rst=1 at posedge, the block SHALL set state=IDLE, rr_ptr=0, mul_a=0, mul_b=0, resp_id=0.
REQ-032 During rst=1, outputs SHALL be forced to req_ready=0, resp_valid=0, busy=0.
REQ-033 Reset in LOAD or RESP SHALL abort the job with no response.

Structure
REQ-034 Package mat_mult_pkg SHALL hold the state enum and the default A_ROWS/A_COLS/B_COLS/NUM_REQ constants.
REQ-035 Sub-module rr_arbiter SHALL implement the combinational round-robin grant from req_valid and rr_ptr; rr_ptr lives in mat_mult_arb.
REQ-036 The multiplier SHALL be instantiated outside this block.

Verification
REQ-037 Single job: req_valid=0001, A rows {FF,0F,01,00}, B=0x81 -> req_ready=0001 for 1 cycle; 2 cycles later resp_valid=1, resp_c=4'b0110 (bit0=row0), resp_id=0.
REQ-038 All requesters valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0 every 3 cycles; no requester starves.
REQ-039 Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_c, resp_id, resp_valid stable; no req_ready pulses; accept on the cycle resp_ready rises.
REQ-040 Wrap: rr_ptr=3, req_valid=0101 -> grant 0; then rr_ptr=1 -> next grant 2.
REQ-041 rst asserted in RESP -> next cycle resp_valid=0, state IDLE, rr_ptr=0; a pending request is then re-granted from index 0.
REQ-042 Identity check: A=I (row i has bit i set), random B -> resp_c equals B[3:0] for every requester.

Source files
------------

// File: rtl/mat_mult_pkg.sv
// Shared types and default geometry for the round-robin multiplier front end.
package mat_mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_A_ROWS  = 4;
    localparam int DEF_A_COLS  = 8;
    localparam int DEF_B_COLS  = 1;

    // A single requester still gets a 1-bit id.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_mult_arb_if.sv
// Requester, multiplier and response bundle for mat_mult_arb.
interface mat_mult_arb_if
    import mat_mult_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int A_ROWS  = DEF_A_ROWS,
    parameter int A_COLS  = DEF_A_COLS,
    parameter int B_COLS  = DEF_B_COLS
);
    localparam int IW = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]                          req_valid;
    logic [NUM_REQ-1:0]                          req_ready;
    logic [NUM_REQ-1:0][A_ROWS-1:0][A_COLS-1:0] req_a;
    logic [NUM_REQ-1:0][A_COLS-1:0][B_COLS-1:0] req_b;
    logic [A_ROWS-1:0][A_COLS-1:0]              mul_a;
    logic [A_COLS-1:0][B_COLS-1:0]              mul_b;
    logic [A_ROWS-1:0][B_COLS-1:0]              mul_c;
    logic                                        resp_valid;
    logic                                        resp_ready;
    logic [A_ROWS-1:0][B_COLS-1:0]              resp_c;
    logic [IW-1:0]                               resp_id;
    logic                                        busy;

    modport master (
        output req_valid, req_a, req_b, mul_c, resp_ready,
        input  req_ready, mul_a, mul_b, resp_valid, resp_c, resp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_c, resp_ready,
        output req_ready, mul_a, mul_b, resp_valid, resp_c, resp_id, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first request at or above the pointer, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int k = 0; k < N; k++) begin
            w_j = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_j >= (IW+1)'(N)) begin
                w_j = w_j - (IW+1)'(N);
            end
            if (!o_any && i_req[w_j[IW-1:0]]) begin
                o_any              = 1'b1;
                o_gnt[w_j[IW-1:0]] = 1'b1;
                o_idx              = w_j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mat_mult_arb.sv
// Shares one registered GF(2) matrix multiplier among NUM_REQ requesters,
// one job at a time: IDLE accepts, LOAD waits out the multiplier, RESP holds.
module mat_mult_arb
    import mat_mult_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int A_ROWS  = DEF_A_ROWS,
    parameter int A_COLS  = DEF_A_COLS,
    parameter int B_COLS  = DEF_B_COLS
) (
    input  logic           clk,
    input  logic           rst,
    mat_mult_arb_if.slave  bus
);

    localparam int IW = id_w(NUM_REQ);

    state_e                        r_state;
    state_e                        w_next;
    logic [IW-1:0]                 r_ptr;
    logic [IW-1:0]                 r_id;
    logic [A_ROWS-1:0][A_COLS-1:0] r_a;
    logic [A_COLS-1:0][B_COLS-1:0] r_b;
    logic [NUM_REQ-1:0]            w_gnt;
    logic [IW-1:0]                 w_idx;
    logic                          w_any;
    logic                          w_accept;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: w_next = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operands stay put after accept so mul_c is steady for the whole RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_id  <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_accept) begin
            r_a   <= bus.req_a[w_idx];
            r_b   <= bus.req_b[w_idx];
            r_id  <= w_idx;
            r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
        end
    end

    assign bus.req_ready  = (!rst && r_state == S_IDLE) ? w_gnt : '0;
    assign bus.resp_valid = !rst && (r_state == S_RESP);
    assign bus.busy       = !rst && (r_state != S_IDLE);
    assign bus.mul_a      = r_a;
    assign bus.mul_b      = r_b;
    assign bus.resp_c     = bus.mul_c;
    assign bus.resp_id    = r_id;

endmodule

// File: tb/tb_mat_mult_arb.sv
// Bench for mat_mult_arb: job-level reference model, per-cycle compare, directed cases.
module tb_mat_mult_arb;
    import mat_mult_pkg::*;

    localparam int NR = 4;
    localparam int R  = 4;
    localparam int C  = 8;
    localparam int BC = 1;
    localparam int IW = id_w(NR);

    typedef logic [R-1:0][C-1:0]  a_t;
    typedef logic [C-1:0][BC-1:0] b_t;
    typedef logic [R-1:0][BC-1:0] c_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mat_mult_arb_if #(.NUM_REQ(NR), .A_ROWS(R), .A_COLS(C), .B_COLS(BC)) bus ();

    mat_mult_arb #(
        .NUM_REQ (NR),
        .A_ROWS  (R),
        .A_COLS  (C),
        .B_COLS  (BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic c_t gf2(input a_t a, input b_t b);
        c_t c;
        logic p;
        c = '0;
        for (int r = 0; r < R; r++) begin
            for (int j = 0; j < BC; j++) begin
                p = 1'b0;
                for (int k = 0; k < C; k++) p = p ^ (a[r][k] & b[k][j]);
                c[r][j] = p;
            end
        end
        return c;
    endfunction

    // External multiplier: one registered stage, no enable.
    always_ff @(posedge clk) bus.mul_c <= gf2(bus.mul_a, bus.mul_b);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [NR-1:0] v, input int p);
        logic [NR-1:0] s;
        for (int k = 0; k < NR; k++) begin
            s = v >> ((p + k) % NR);
            if (s[0]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NR-1:0] v);
        logic [NR-1:0] s;
        for (int i = 0; i < NR; i++) begin
            s = v >> i;
            if (s[0]) return i;
        end
        return -1;
    endfunction

    // Job-level model: one job in flight, result due two cycles after accept.
    int cyc = 0;
    bit m_act = 0;
    int m_acc = 0;
    int m_ptr = 0;
    int m_id = 0;
    a_t m_a;
    b_t m_b;

    initial begin : model
        int g;
        forever begin
            @(posedge clk);
            g = model_grant(bus.req_valid, m_ptr);
            if (rst) begin
                m_act = 0;
                m_ptr = 0;
            end else if (!m_act) begin
                if (g >= 0) begin
                    m_act = 1;
                    m_acc = cyc;
                    m_id  = g;
                    m_a   = bus.req_a[IW'(g)];
                    m_b   = bus.req_b[IW'(g)];
                    m_ptr = (g + 1) % NR;
                end
            end else if (cyc >= m_acc + 2 && bus.resp_ready) begin
                m_act = 0;
            end
            cyc++;
        end
    end

    initial begin : compare
        logic [NR-1:0] er;
        logic ev;
        int g;
        forever begin
            @(negedge clk);
            er = '0;
            g  = model_grant(bus.req_valid, m_ptr);
            if (!rst && !m_act && g >= 0) er = NR'(1) << g;
            ev = !rst && m_act && (cyc >= m_acc + 2);
            chk("req_ready", 64'(bus.req_ready), 64'(er));
            chk("busy", 64'(bus.busy), 64'(!rst && m_act));
            chk("resp_valid", 64'(bus.resp_valid), 64'(ev));
            if (ev) begin
                chk("resp_c", 64'(bus.resp_c), 64'(gf2(m_a, m_b)));
                chk("resp_id", 64'(bus.resp_id), 64'(m_id));
            end
            if (!rst && m_act) begin
                chk("mul_a", 64'(bus.mul_a), 64'(m_a));
                chk("mul_b", 64'(bus.mul_b), 64'(m_b));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.resp_valid) chk(nm, 64'(0), 64'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.resp_ready = 1'b1;
        while (bus.busy && n < 20) begin
            tick();
            n++;
        end
        chk("drain_idle", 64'(bus.busy), 64'(0));
    endtask

    task automatic t_single();
        a_t a;
        b_t b;
        a = {8'h00, 8'h01, 8'h0F, 8'hFF};
        b = 8'h81;
        chk("model_pin", 64'(gf2(a, b)), 64'h6);
        do_reset();
        chk("rst_mul_a", 64'(bus.mul_a), 64'(0));
        chk("rst_resp_id", 64'(bus.resp_id), 64'(0));
        bus.req_a[0] = a;
        bus.req_b[0] = b;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("single_ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("single_load_valid", 64'(bus.resp_valid), 64'(0));
        chk("single_load_busy", 64'(bus.busy), 64'(1));
        tick();
        @(negedge clk);
        chk("single_valid", 64'(bus.resp_valid), 64'(1));
        chk("single_c", 64'(bus.resp_c), 64'h6);
        chk("single_id", 64'(bus.resp_id), 64'(0));
        tick();
        @(negedge clk);
        chk("single_done", 64'(bus.busy), 64'(0));
    endtask

    task automatic t_rr_order();
        int gi[$];
        int gt[$];
        do_reset();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[IW'(i)] = a_t'($urandom);
            bus.req_b[IW'(i)] = b_t'($urandom);
        end
        bus.req_valid = 4'b1111;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (bus.req_ready != 0) begin
                gi.push_back(oh_idx(bus.req_ready));
                gt.push_back(t);
            end
            tick();
        end
        bus.req_valid = '0;
        chk("rr_count", 64'(gi.size() >= 5), 64'(1));
        for (int k = 0; k < 5; k++) begin
            if (k < gi.size()) begin
                chk("rr_order", 64'(gi[k]), 64'(k % NR));
                chk("rr_gap", 64'(gt[k] - gt[0]), 64'(3 * k));
            end
        end
        drain();
    endtask

    task automatic t_backpressure();
        c_t snap;
        do_reset();
        bus.req_a[1] = a_t'($urandom);
        bus.req_b[1] = b_t'($urandom);
        bus.resp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("bp_ready", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 4'b1111;
        wait_valid("bp_timeout");
        snap = bus.resp_c;
        chk("bp_c", 64'(snap), 64'(gf2(bus.req_a[1], bus.req_b[1])));
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(bus.resp_valid), 64'(1));
            chk("bp_c_stable", 64'(bus.resp_c), 64'(snap));
            chk("bp_id", 64'(bus.resp_id), 64'(1));
            chk("bp_no_ready", 64'(bus.req_ready), 64'(0));
            tick();
            @(negedge clk);
        end
        tick();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_valid", 64'(bus.resp_valid), 64'(1));
        tick();
        @(negedge clk);
        chk("bp_next_grant", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = '0;
        drain();
    endtask

    task automatic t_wrap();
        do_reset();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[IW'(i)] = a_t'($urandom);
            bus.req_b[IW'(i)] = b_t'($urandom);
        end
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("wrap_first", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = '0;
        wait_valid("wrap_timeout1");
        tick();
        bus.req_valid = 4'b0101;
        @(negedge clk);
        chk("wrap_grant0", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 4'b0100;
        wait_valid("wrap_timeout2");
        tick();
        @(negedge clk);
        chk("wrap_grant2", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = '0;
        drain();
    endtask

    task automatic t_reset_resp();
        do_reset();
        bus.resp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("rr_accept0", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 4'b0011;
        wait_valid("rstresp_timeout");
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(bus.resp_valid), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_ready", 64'(bus.req_ready), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_regrant0", 64'(bus.req_ready), 64'h1);
        chk("rst_after_valid", 64'(bus.resp_valid), 64'(0));
        tick();
        bus.req_valid = '0;
        drain();
    endtask

    task automatic t_identity();
        a_t a;
        b_t b;
        for (int r = 0; r < R; r++) a[r] = C'(1) << r;
        for (int i = 0; i < NR; i++) begin
            b = b_t'($urandom);
            bus.req_a[IW'(i)] = a;
            bus.req_b[IW'(i)] = b;
            bus.req_valid = NR'(1) << i;
            tick();
            bus.req_valid = '0;
            wait_valid("ident_timeout");
            chk("ident_c", 64'(bus.resp_c), 64'(b[3:0]));
            chk("ident_id", 64'(bus.resp_id), 64'(i));
            tick();
            drain();
        end
    endtask

    task automatic t_random();
        logic [NR-1:0] pend;
        logic [NR-1:0] rdy;
        pend = '0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rdy = bus.req_ready;
            tick();
            rst = ($urandom_range(199) == 0);
            for (int i = 0; i < NR; i++) begin
                if (rdy[IW'(i)]) pend[IW'(i)] = 1'b0;
                if (!pend[IW'(i)] && $urandom_range(2) == 0) begin
                    pend[IW'(i)] = 1'b1;
                    bus.req_a[IW'(i)] = a_t'($urandom);
                    bus.req_b[IW'(i)] = b_t'($urandom);
                end
            end
            bus.req_valid  = pend;
            bus.resp_ready = ($urandom_range(3) != 0);
        end
        rst = 1'b0;
        bus.req_valid = '0;
        drain();
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        t_single();
        t_rr_order();
        t_backpressure();
        t_wrap();
        t_reset_resp();
        t_identity();
        t_random();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
